// File: rtl/rr_arb8_16_pkg.sv
// Shared types and constants for the 8-way, 16-bit round-robin arbiter.
//   N_REQ  : number of requesters (fixed by the 8-way mux)
//   DATA_W : lane width (fixed by the 16-bit mux)
//   SEL_W  : select width
//   state_e: arbiter state
//   onehot : index to one-hot helper
package rr_arb8_16_pkg;

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arb8_16_if.sv
// Requester/sink bundle of the round-robin arbiter.
//   req       : per-requester request
//   data_in   : 8 packed 16-bit lanes, lane i at [16*i +: 16]
//   ack       : one-hot acknowledge on acceptance
//   gnt       : one-hot grant, zero when idle
//   out_valid : output word valid
//   out_ready : sink ready
//   out_data  : selected lane, zero when idle
//   out_src   : granted requester index, zero when idle
// master = arbiter side, slave = requesters and sink.
interface rr_arb8_16_if;
  import rr_arb8_16_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] data_in;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ-1:0]        gnt;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [SEL_W-1:0]        out_src;

  modport master (
    input  req, data_in, out_ready,
    output ack, gnt, out_valid, out_data, out_src
  );

  modport slave (
    output req, data_in, out_ready,
    input  ack, gnt, out_valid, out_data, out_src
  );

endinterface

// File: rtl/Mux8Way16.sv
// Existing 8-way 16-bit datapath mux.
//   a..h : input words, sel : select (0 -> a ... 7 -> h), out : selected word
module Mux8Way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic [2:0]  sel,
  output logic [15:0] out
);

  always_comb begin
    out = a;
    unique case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/rr_arb8_16_pick.sv
// Round-robin pick: first set bit of mask_i scanning start_i, start_i+1, ... (mod 8).
//   mask_i   : candidate requests
//   start_i  : highest-priority index
//   any_o    : some candidate present
//   idx_o    : winning index
//   onehot_o : winning index as one-hot (zero when none)
module rr_pick8
  import rr_arb8_16_pkg::*;
(
  input  logic [N_REQ-1:0] mask_i,
  input  logic [SEL_W-1:0] start_i,
  output logic             any_o,
  output logic [SEL_W-1:0] idx_o,
  output logic [N_REQ-1:0] onehot_o
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  // Rotate so start_i lands at bit 0, then the lowest set bit is the winner.
  always_comb begin
    rot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rot[k] = mask_i[SEL_W'(start_i + SEL_W'(k))];
    end
  end

  always_comb begin
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = SEL_W'(k);
    end
  end

  // Rotate back: 3-bit add wraps naturally.
  assign any_o    = |mask_i;
  assign idx_o    = start_i + off;
  assign onehot_o = any_o ? onehot(idx_o) : '0;

endmodule

// File: rtl/rr_arb8_16.sv
// Round-robin arbiter sharing one 16-bit valid/ready channel among 8 requesters.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus_io : requester lanes, ack/grant and output channel (master side)
// A grant is held until the sink accepts the word or the requester withdraws
// (abort: no ack, priority pointer untouched). On acceptance priority moves to
// sel+1 and the next winner is picked in the same cycle, so transfers stream
// without bubbles.
module rr_arb8_16
  import rr_arb8_16_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  rr_arb8_16_if.master bus_io
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  logic             busy, hold, xfer;
  logic [SEL_W-1:0] sel_inc;
  logic [N_REQ-1:0] pick_mask;
  logic [SEL_W-1:0] pick_start;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic [DATA_W-1:0] mux_out;

  assign busy    = (state_q == StBusy);
  assign hold    = bus_io.req[sel_q];
  assign xfer    = busy & hold & bus_io.out_ready;
  assign sel_inc = sel_q + SEL_W'(1);

  // While busy the only decision point is a handshake, where the current
  // winner is excluded and the scan starts just past it.
  assign pick_mask  = busy ? (bus_io.req & ~onehot(sel_q)) : bus_io.req;
  assign pick_start = busy ? sel_inc : ptr_q;

  rr_pick8 u_pick (
    .mask_i   (pick_mask),
    .start_i  (pick_start),
    .any_o    (pick_any),
    .idx_o    (pick_idx),
    .onehot_o (pick_oh)
  );

  Mux8Way16 u_mux (
    .a   (bus_io.data_in[0*DATA_W +: DATA_W]),
    .b   (bus_io.data_in[1*DATA_W +: DATA_W]),
    .c   (bus_io.data_in[2*DATA_W +: DATA_W]),
    .d   (bus_io.data_in[3*DATA_W +: DATA_W]),
    .e   (bus_io.data_in[4*DATA_W +: DATA_W]),
    .f   (bus_io.data_in[5*DATA_W +: DATA_W]),
    .g   (bus_io.data_in[6*DATA_W +: DATA_W]),
    .h   (bus_io.data_in[7*DATA_W +: DATA_W]),
    .sel (sel_q),
    .out (mux_out)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StBusy;
          sel_d   = pick_idx;
          gnt_d   = pick_oh;
        end
      end
      StBusy: begin
        if (!hold) begin
          // Withdrawn request: drop the grant, keep the pointer.
          state_d = StIdle;
          gnt_d   = '0;
        end else if (bus_io.out_ready) begin
          ptr_d = sel_inc;
          if (pick_any) begin
            sel_d = pick_idx;
            gnt_d = pick_oh;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus_io.gnt       = gnt_q;
  assign bus_io.out_valid = busy;
  assign bus_io.out_src   = busy ? sel_q : '0;
  assign bus_io.out_data  = busy ? mux_out : '0;
  assign bus_io.ack       = xfer ? onehot(sel_q) : '0;

endmodule

// File: tb/tb_rr_arb8_16.sv
// Self-checking bench for rr_arb8_16: directed scenarios followed by random
// traffic, every cycle compared against a behavioural round-robin model.
module tb_rr_arb8_16;

  logic clk;
  logic rst_n;

  rr_arb8_16_if bus ();

  rr_arb8_16 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Model state: granted requester (-1 = idle) and priority start index.
  int          cur   = -1;
  int          ptr   = 0;
  bit          known = 1'b0;
  logic [15:0] lane [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [7:0] m, input int start);
    for (int k = 0; k < 8; k++) begin
      if (m[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic step(input logic [7:0] r, input logic rdy, input logic rst);
    logic [7:0]  exp_ack, exp_gnt;
    logic [15:0] exp_data;
    @(negedge clk);
    bus.req       = r;
    bus.out_ready = rdy;
    rst_n         = rst;
    for (int i = 0; i < 8; i++) bus.data_in[16*i +: 16] = lane[i];
    #1;
    if (known) begin
      exp_gnt  = (cur >= 0) ? 8'(1 << cur) : 8'h00;
      exp_data = (cur >= 0) ? lane[cur] : 16'h0000;
      exp_ack  = (cur >= 0 && rdy && r[cur]) ? 8'(1 << cur) : 8'h00;
      check_eq("out_valid", {31'd0, bus.out_valid}, {31'd0, cur >= 0});
      check_eq("out_src", {29'd0, bus.out_src}, (cur >= 0) ? cur : 0);
      check_eq("out_data", {16'd0, bus.out_data}, {16'd0, exp_data});
      check_eq("ack", {24'd0, bus.ack}, {24'd0, exp_ack});
      check_eq("gnt", {24'd0, bus.gnt}, {24'd0, exp_gnt});
    end
    @(posedge clk);
    if (!rst) begin
      cur   = -1;
      ptr   = 0;
      known = 1'b1;
    end else if (cur < 0) begin
      cur = first_from(r, ptr);
    end else if (!r[cur]) begin
      cur = -1;
    end else if (rdy) begin
      ptr = (cur + 1) % 8;
      cur = first_from(r & ~(8'd1 << cur), ptr);
    end
  endtask

  initial begin
    logic [7:0] r;
    logic       rdy, rst;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    bus.data_in   = '0;
    rst_n         = 1'b0;
    for (int i = 0; i < 8; i++) lane[i] = 16'h0000;

    step(8'h00, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);

    // Single requester.
    lane[2] = 16'hBEEF;
    step(8'h04, 1'b1, 1'b1);
    step(8'h04, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);

    // Full contention.
    for (int i = 0; i < 8; i++) lane[i] = 16'h1000 + 16'(i);
    for (int i = 0; i < 11; i++) step(8'hFF, 1'b1, 1'b1);

    // Backpressure from a fresh pointer.
    step(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(8'h81, 1'b0, 1'b1);
    step(8'h81, 1'b1, 1'b1);
    step(8'h80, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);

    // Pointer wrap: last grant 6, then 7, then 0.
    step(8'h00, 1'b1, 1'b0);
    step(8'h40, 1'b1, 1'b1);
    step(8'h40, 1'b1, 1'b1);
    step(8'h81, 1'b1, 1'b1);
    step(8'h81, 1'b1, 1'b1);
    step(8'h01, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);

    // Abort keeps the pointer.
    step(8'h00, 1'b1, 1'b0);
    step(8'h08, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'h28, 1'b1, 1'b1);
    step(8'h28, 1'b1, 1'b1);
    step(8'h20, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);

    // Reset while busy.
    step(8'h10, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b0);
    step(8'h12, 1'b1, 1'b1);
    step(8'h12, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);

    // Random traffic honouring the hold-until-ack rule most of the time.
    for (int n = 0; n < 1500; n++) begin
      r   = 8'($urandom);
      rdy = ($urandom_range(3) != 0);
      rst = ($urandom_range(99) != 0);
      if (cur >= 0) r[cur] = ($urandom_range(15) != 0);
      for (int i = 0; i < 8; i++) begin
        if (i != cur) lane[i] = 16'($urandom);
      end
      step(r, rdy, rst);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arb8_16.md
Name: rr_arb8_16

Overview:
Round-robin arbiter and sequencer that shares one 16-bit output channel among 8 requesters.
It owns the 3-bit select driving the existing 8-way 16-bit mux datapath and holds each grant until the downstream consumer accepts the word.
It issues a per-requester acknowledge on acceptance, then rotates priority so no requester starves.
It sits between eight word producers and a single 16-bit sink with a valid/ready interface.

Parameters:
N_REQ, 8, number of requesters; fixed by the 8-way mux, not overridable
DATA_W, 16, lane width; fixed by the 16-bit mux
SEL_W, 3, select width (log2 N_REQ)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active low; sampled on rising edge of clk
req  input  8  req[i] high = requester i has a word on its lane
data_in  input  128  lane i = data_in[16*i+15 : 16*i]
ack  output  8  one-hot; ack[i]=1 for exactly the cycle lane i's word is accepted
gnt  output  8  one-hot registered grant; all zero when idle
out_valid  output  1  output channel holds a valid word
out_ready  input  1  sink accepts the word when out_valid & out_ready
out_data  output  16  selected lane; forced 0 when out_valid=0
out_src  output  3  index of the granted requester; 0 when idle

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, sel=0, ptr=0, gnt=0, out_valid=0, out_src=0, out_data=0, ack=0. Reset mid-transfer discards the grant; no ack is issued.
- State IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, …, 7, 0, … (mod 8).
  - Next cycle: sel=winner, gnt=onehot(winner), out_valid=1, state=BUSY.
  - Arbitration latency from req rising to out_valid is 1 cycle.
- State BUSY:
  - out_data = data_in lane[sel], combinational through the mux. The requester must hold req and data stable until ack.
  - out_src = sel.
- Handshake cycle (out_valid & out_ready):
  - ack[sel]=1 combinationally in the same cycle.
  - ptr <= sel+1 (wraps 7→0).
  - Re-arbitrate in the same cycle over req & ~onehot(sel), starting from sel+1.
  - If a winner exists: next cycle BUSY with the new sel and gnt. Back-to-back transfers have no bubble.
  - Otherwise: next cycle IDLE with out_valid=0 and gnt=0.
- A requester may reassert req the cycle after its ack. It re-enters arbitration at the next decision point.
- req[sel] drops while BUSY and out_ready=0 (protocol abort):
  - No ack; state returns to IDLE next cycle with out_valid=0.
  - ptr is unchanged, so the aborting requester keeps its priority position.
- req[sel] drops in the same cycle as out_ready=1: treated as the abort case; no ack, no transfer.
- out_ready held low: grant, sel and out_data are held indefinitely. No timeout.
- Only one grant at a time; gnt is always zero or one-hot. ack is one-hot or zero, and nonzero only when out_valid & out_ready & req[sel].
- Fairness: with all 8 requesting continuously and out_ready=1, grant order is 0,1,…,7,0,… and each requester gets exactly one transfer per 8 cycles.
- Priority pointer is 3-bit modular; sel+1 wraps naturally with no overflow flag.

Decomposition:
- Shared package rr_arb_pkg:
  - N_REQ=8, DATA_W=16, SEL_W=3
  - state enum {IDLE, BUSY}
  - onehot-from-index helper function
- One natural sub-module, rr_pick8 (combinational): inputs mask[7:0] and start[2:0]; outputs any, idx[2:0], onehot[7:0].
  - Implemented as a rotate, then a fixed-priority scan, then a rotate back.
- Data steering instantiates the existing Mux8Way16 with sel as its select. The arbiter adds no separate datapath mux.

Test Plan:
- Single requester: reset, req=8'h04, lane2=16'hBEEF, out_ready=1 → cycle+1 out_valid=1, out_src=2, out_data=BEEF, ack=8'h04 that cycle; then IDLE, ptr=3.
- Full contention: req=8'hFF held, lane i=16'h1000+i, out_ready=1 → out_src sequence 0..7,0, one ack per cycle, no bubbles, out_data tracks 1000..1007.
- Backpressure: req=8'h81, out_ready=0 for 5 cycles → out_src=0 and out_data stable, ack=0; raise out_ready → ack=8'h01, next grant src=7 on the following cycle.
- Wrap: ptr=7 (last grant src=6), req=8'h81 → next grant src=7, then src=0.
- Abort: grant src=3, drop req[3] with out_ready=0 → no ack, out_valid=0 next cycle; reassert req[3] with req[5] → src=3 wins (ptr unchanged).
- Reset mid-BUSY: rst_n=0 one cycle while out_valid=1 → all outputs 0, gnt=0, next arbitration starts from ptr=0.
